// File: rtl/vga_fetch_arbiter.sv
// Pixel memory arbiter: display prefetch (strict priority) plus host read/write port,
// with a 1bpp serialiser that tracks the beam one word ahead.
module vga_fetch_arbiter #(
    parameter int H_DISPLAY = 800,
    parameter int V_DISPLAY = 600,
    parameter int H_MAX     = 1055,
    parameter int V_MAX     = 627,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       x,
    input  logic [9:0]        y,
    input  logic              displayOn,
    output logic              pixel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid
);
    localparam int WPL = H_DISPLAY / DATA_W;
    localparam int SH  = $clog2(DATA_W);
    localparam logic [SH-1:0] FETCH_PH = SH'(DATA_W - 4);
    localparam logic [SH-1:0] LOAD_PH  = SH'(DATA_W - 1);

    logic [ADDR_W-1:0] cur_base_q, cur_base_d;
    logic [ADDR_W-1:0] nxt_base_q, nxt_base_d;
    logic [DATA_W-1:0] pending_q, pending_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] host_rdata_q;
    logic              disp_rd_q, disp_rd_d;
    logic              host_rd_q, host_rd_d;

    logic [10:0]       word_k;
    logic [9:0]        nr;
    logic              fetch_line, fetch_next, fetch_due, load;
    logic [ADDR_W-1:0] disp_addr;

    assign word_k = x >> SH;

    always_comb begin
        nr         = (y == 10'(V_MAX)) ? 10'd0 : y + 10'd1;
        fetch_line = (x[SH-1:0] == FETCH_PH) && (word_k + 11'd1 < 11'(WPL)) &&
                     (y < 10'(V_DISPLAY));
        fetch_next = (x == 11'(H_MAX - 3)) && (nr < 10'(V_DISPLAY));
        fetch_due  = fetch_line || fetch_next;
        disp_addr  = fetch_line ? cur_base_q + ADDR_W'(word_k) + ADDR_W'(1) : nxt_base_q;
        load       = ((x[SH-1:0] == LOAD_PH) && (x < 11'(H_DISPLAY - 1))) ||
                     (x == 11'(H_MAX));
    end

    // Held in reset the memory and host strobes go quiet immediately, not at the next edge.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        host_gnt  = 1'b0;
        if (rst_n) begin
            if (fetch_due) begin
                mem_en   = 1'b1;
                mem_addr = disp_addr;
            end else if (host_req) begin
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                host_gnt  = 1'b1;
            end
        end
    end

    // Line bases step by WPL at each line end so no multiplier is needed.
    always_comb begin
        cur_base_d = cur_base_q;
        nxt_base_d = nxt_base_q;
        if (x == 11'(H_MAX)) begin
            cur_base_d = nxt_base_q;
            nxt_base_d = (nr == 10'(V_MAX)) ? '0 : nxt_base_q + ADDR_W'(WPL);
        end
    end

    always_comb begin
        disp_rd_d   = mem_en && !host_gnt;
        host_rd_d   = host_gnt && !host_we;
        pending_d   = disp_rd_q ? mem_rdata : pending_q;
        shift_d     = load ? pending_q : (shift_q << 1);
        host_rvalid = host_rd_q;
        host_rdata  = host_rd_q ? mem_rdata : host_rdata_q;
        pixel       = displayOn & shift_q[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_base_q   <= '0;
            nxt_base_q   <= '0;
            pending_q    <= '0;
            shift_q      <= '0;
            host_rdata_q <= '0;
            disp_rd_q    <= 1'b0;
            host_rd_q    <= 1'b0;
        end else begin
            cur_base_q   <= cur_base_d;
            nxt_base_q   <= nxt_base_d;
            pending_q    <= pending_d;
            shift_q      <= shift_d;
            host_rdata_q <= host_rdata;
            disp_rd_q    <= disp_rd_d;
            host_rd_q    <= host_rd_d;
        end
    end
endmodule
